// File: rtl/sisc_fetch_unit.sv
// Instruction fetch unit for the SISC controller: owns PC, IR and STAT, and
// fetches 32-bit words from instruction memory over a rd/valid handshake.
module sisc_fetch_unit #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_req,
  input  logic          pc_write,
  input  logic [AW-1:0] br_addr,
  input  logic          stat_en,
  input  logic [3:0]    cc,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_data,
  input  logic          imem_valid,
  output logic [AW-1:0] pc,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [3:0]    rd,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [15:0]   imm,
  output logic [3:0]    stat,
  output logic          ir_valid,
  output logic          busy,
  output logic          fault,
  output logic [1:0]    fsm_state
);

  // Handshake: imem_rd rises with imem_addr and both hold steady until the
  // cycle imem_valid is sampled high in WAIT; imem_valid is ignored elsewhere.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [7:0]  LAST_WAIT = 8'(TIMEOUT - 1);
  localparam logic [31:0] HLT_WORD  = 32'hF000_0000;

  state_t        state;
  logic [31:0]   ir;
  logic          pend;
  logic [AW-1:0] pend_addr;
  logic [7:0]    cnt;
  logic [AW-1:0] fetch_addr;

  assign fetch_addr = pc_write ? br_addr : pc;

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      stat      <= '0;
      imem_rd   <= 1'b0;
      imem_addr <= '0;
      ir_valid  <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      pend      <= 1'b0;
      pend_addr <= '0;
      cnt       <= '0;
    end else begin
      if (stat_en) stat <= cc;
      case (state)
        IDLE: begin
          if (fetch_req) begin
            pc        <= fetch_addr;
            imem_addr <= fetch_addr;
            imem_rd   <= 1'b1;
            ir_valid  <= 1'b0;
            busy      <= 1'b1;
            pend      <= 1'b0;
            cnt       <= '0;
            state     <= WAIT;
          end else if (pc_write) begin
            pc <= br_addr;
          end
        end
        WAIT: begin
          if (imem_valid) begin
            ir       <= imem_data;
            ir_valid <= 1'b1;
            imem_rd  <= 1'b0;
            busy     <= 1'b0;
            pend     <= 1'b0;
            state    <= IDLE;
            // A branch arriving with the data still beats the increment.
            if (pc_write)  pc <= br_addr;
            else if (pend) pc <= pend_addr;
            else           pc <= pc + 1'b1;
          end else begin
            if (pc_write) begin
              pend      <= 1'b1;
              pend_addr <= br_addr;
            end
            if (cnt == LAST_WAIT) begin
              ir       <= HLT_WORD;
              ir_valid <= 1'b1;
              imem_rd  <= 1'b0;
              busy     <= 1'b0;
              fault    <= 1'b1;
              state    <= FAULT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

  assign opcode    = ir[31:28];
  assign mm        = ir[27:24];
  assign rd        = ir[23:20];
  assign rs        = ir[19:16];
  assign rt        = ir[15:12];
  assign imm       = ir[15:0];
  assign fsm_state = state;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit: a table of fetch transactions plus
// hand-written sequences for reset-mid-fetch, STAT updates and timeout.
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        fetch_req = 1'b0;
  logic        pc_write = 1'b0;
  logic [15:0] br_addr = '0;
  logic        stat_en = 1'b0;
  logic [3:0]  cc = '0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        imem_valid = 1'b0;
  logic [15:0] pc;
  logic [3:0]  opcode, mm, rd, rs, rt, stat;
  logic [15:0] imm;
  logic        ir_valid, busy, fault;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  sisc_fetch_unit #(.AW(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_f(rst_f), .fetch_req(fetch_req), .pc_write(pc_write),
    .br_addr(br_addr), .stat_en(stat_en), .cc(cc), .imem_rd(imem_rd),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
    .pc(pc), .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .stat(stat), .ir_valid(ir_valid), .busy(busy), .fault(fault),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pre_wr;
    logic [15:0] pre_addr;
    logic        fetch_br;
    logic [15:0] br;
    int          lat;
    int          w1_cyc;
    logic [15:0] w1_addr;
    int          w2_cyc;
    logic [15:0] w2_addr;
    logic [31:0] data;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.pre_wr) begin
      @(negedge clk);
      pc_write = 1'b1; br_addr = v.pre_addr;
      @(posedge clk); #1;
      chk("pre_pc", 32'(pc), 32'(v.pre_addr));
      @(negedge clk);
      pc_write = 1'b0;
    end
    @(negedge clk);
    fetch_req = 1'b1; pc_write = v.fetch_br; br_addr = v.br;
    @(posedge clk); #1;
    chk("fetch_rd", 32'(imem_rd), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(v.exp_addr));
    chk("fetch_busy", 32'(busy), 32'd1);
    chk("fetch_ir_valid", 32'(ir_valid), 32'd0);
    for (int c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      fetch_req = (c == 1);
      pc_write = 1'b0;
      if (c == v.w1_cyc) begin pc_write = 1'b1; br_addr = v.w1_addr; end
      if (c == v.w2_cyc) begin pc_write = 1'b1; br_addr = v.w2_addr; end
      imem_valid = (c == v.lat);
      imem_data = (c == v.lat) ? v.data : 32'hDEAD_BEEF;
      @(posedge clk); #1;
      if (c < v.lat) begin
        chk("wait_rd", 32'(imem_rd), 32'd1);
        chk("wait_addr", 32'(imem_addr), 32'(v.exp_addr));
        chk("wait_pc", 32'(pc), 32'(v.exp_addr));
        chk("wait_state", 32'(fsm_state), 32'd1);
      end
    end
    chk("done_ir_valid", 32'(ir_valid), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rd", 32'(imem_rd), 32'd0);
    chk("done_ir", {opcode, mm, rd, rs, imm}, v.data);
    chk("done_rt", 32'(rt), 32'(v.data[15:12]));
    chk("done_pc", 32'(pc), 32'(v.exp_pc));
    chk("done_state", 32'(fsm_state), 32'd0);
    @(negedge clk);
    fetch_req = 1'b0; pc_write = 1'b0; imem_valid = 1'b0;
  endtask

  initial begin
    int edges;
    //          pre    pre_addr  fbr   br       lat w1 w1_addr  w2 w2_addr  data          addr     pc
    vecs[0] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 32'h2A3C_0005, 16'h0000, 16'h0001};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 4, 2, 16'h0040, 0, 16'h0000, 32'h1234_5678, 16'h0001, 16'h0040};
    vecs[2] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 2, 0, 16'h0000, 0, 16'h0000, 32'h3111_2222, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 16'h0100, 1, 0, 16'h0000, 0, 16'h0000, 32'h4567_89AB, 16'h0100, 16'h0101};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3, 1, 16'h0300, 3, 16'h0200, 32'hABCD_EF01, 16'h0101, 16'h0200};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 2, 0, 16'h0000, 0, 16'h0000, 32'h5F0E_1234, 16'h0200, 16'h0201};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", {opcode, mm, rd, rs, imm}, 32'd0);
    chk("rst_flags", {28'd0, imem_rd, ir_valid, busy, fault}, 32'd0);
    chk("rst_stat", 32'(stat), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    @(negedge clk);
    rst_f = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // imem_valid while IDLE is ignored
    imem_valid = 1'b1; imem_data = 32'h9999_9999;
    @(posedge clk); #1;
    chk("idle_valid_ir", {opcode, mm, rd, rs, imm}, 32'h5F0E_1234);
    chk("idle_valid_pc", 32'(pc), 32'h0201);
    @(negedge clk);
    imem_valid = 1'b0;

    // STAT update mid-fetch, then reset mid-WAIT followed by a late valid
    fetch_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0; stat_en = 1'b1; cc = 4'b0101;
    @(posedge clk); #1;
    chk("stat_wait", 32'(stat), 32'h5);
    chk("stat_busy", 32'(busy), 32'd1);
    chk("stat_addr", 32'(imem_addr), 32'h0201);
    @(negedge clk);
    stat_en = 1'b0; rst_f = 1'b1;
    @(posedge clk); #1;
    chk("midrst_flags", {28'd0, imem_rd, ir_valid, busy, fault}, 32'd0);
    chk("midrst_stat", 32'(stat), 32'd0);
    @(negedge clk);
    rst_f = 1'b0; imem_valid = 1'b1; imem_data = 32'h7777_7777;
    @(posedge clk); #1;
    chk("late_ir", {opcode, mm, rd, rs, imm}, 32'd0);
    chk("late_pc", 32'(pc), 32'd0);
    chk("late_ir_valid", 32'(ir_valid), 32'd0);
    chk("late_state", 32'(fsm_state), 32'd0);
    @(negedge clk);
    imem_valid = 1'b0;

    // Timeout: 15 WAIT cycles with no valid
    fetch_req = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    fetch_req = 1'b0;
    while (!fault && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 14) chk("pre_timeout_fault", 32'(fault), 32'd0);
    end
    chk("timeout_edges", 32'(edges), 32'd16);
    chk("timeout_opcode", 32'(opcode), 32'hF);
    chk("timeout_flags", {28'd0, imem_rd, ir_valid, busy, fault}, 32'b0101);
    chk("timeout_state", 32'(fsm_state), 32'd2);
    @(negedge clk);
    fetch_req = 1'b1; stat_en = 1'b1; cc = 4'b1010;
    imem_valid = 1'b1; imem_data = 32'h1111_1111;
    repeat (3) @(posedge clk);
    #1;
    chk("fault_sticky", {28'd0, imem_rd, ir_valid, busy, fault}, 32'b0101);
    chk("fault_ir", {opcode, mm, rd, rs, imm}, 32'hF000_0000);
    chk("fault_stat", 32'(stat), 32'hA);
    @(negedge clk);
    fetch_req = 1'b0; stat_en = 1'b0; imem_valid = 1'b0; rst_f = 1'b1;
    @(posedge clk); #1;
    chk("fault_rst", {28'd0, imem_rd, ir_valid, busy, fault}, 32'd0);
    chk("fault_rst_state", 32'(fsm_state), 32'd0);
    @(negedge clk);
    rst_f = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
- Instruction-side source for the SISC control FSM: owns PC, instruction register (IR) and status register (STAT); drives the opcode/mm/stat inputs the controller consumes.
- Fetches 32-bit instruction words from instruction memory over a request/valid handshake on controller demand.
- Applies controller-issued PC loads (branch/jump targets) and ALU condition-code updates.

Parameters:
- AW, 16, instruction address / PC width
- TIMEOUT, 15, max cycles waiting for imem_valid before fault (1..255)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_f  in  1  reset; synchronous, active-high
- fetch_req  in  1  controller request to fetch instruction at current PC (one-cycle pulse or level)
- pc_write  in  1  load PC from br_addr
- br_addr  in  AW  branch/jump target
- stat_en  in  1  load STAT from cc
- cc  in  4  ALU condition codes {C,V,N,Z}
- imem_rd  out  1  memory read request
- imem_addr  out  AW  read address
- imem_data  in  32  returned instruction word
- imem_valid  in  1  imem_data valid this cycle
- pc  out  AW  current PC
- opcode  out  4  IR[31:28]
- mm  out  4  IR[27:24]
- rd  out  4  IR[23:20]
- rs  out  4  IR[19:16]
- rt  out  4  IR[15:12]
- imm  out  16  IR[15:0]
- stat  out  4  STAT register
- ir_valid  out  1  IR holds a completed fetch
- busy  out  1  fetch in flight
- fault  out  1  fetch timeout occurred (sticky)

Behaviour:
- Reset (rst_f=1 at edge): pc=0, IR=0 (opcode NOOP), stat=0, imem_rd=0, imem_addr=0, ir_valid=0, busy=0, fault=0, pending-branch flag cleared, timeout counter=0, state=IDLE. Reset mid-fetch abandons the fetch; a late imem_valid after reset is ignored (state IDLE).
- States: IDLE, WAIT, FAULT.
- IDLE: on fetch_req=1 -> WAIT next cycle; imem_rd=1 and imem_addr=pc registered same edge; ir_valid cleared; busy=1.
- fetch_req and pc_write together in IDLE: pc and imem_addr both take br_addr; fetch uses target.
- pc_write alone in IDLE: pc<=br_addr next cycle.
- WAIT: imem_rd and imem_addr held stable until completion. Counter increments each WAIT cycle.
- Completion: imem_valid=1 in WAIT -> IR<=imem_data, ir_valid=1, imem_rd=0, busy=0, state IDLE; pc<=pc+1 (mod 2^AW, 0xFFFF wraps to 0x0000) unless a pending branch exists, in which case pc<=pending target and flag clears. Minimum latency fetch_req to ir_valid: 2 edges (valid on first WAIT cycle).
- pc_write during WAIT: target latched as pending (last write wins); pc output unchanged until completion. pc_write in same cycle as imem_valid: treated as pending, target wins over increment.
- fetch_req while busy or in FAULT: ignored.
- Timeout: counter reaching TIMEOUT with imem_valid=0 -> FAULT: imem_rd=0, IR<=0xF0000000 (HLT opcode so controller halts), ir_valid=1, fault=1, busy=0. FAULT exits only via reset.
- imem_valid outside WAIT: ignored.
- STAT: stat_en=1 -> stat<=cc next edge, in any state including FAULT; independent of fetch.
- Field outputs combinational from IR; imm overlaps rt by design.

Test Plan:
- Reset then fetch_req, memory returns 0x2A3C_0005 one cycle later -> imem_addr=0, ir_valid high after 2 edges, opcode=2, mm=0xA, rd=3, rs=0xC, imm=0x0005, pc=1.
- Memory latency 4 cycles with pc_write(br_addr=0x0040) in 2nd WAIT cycle -> imem_addr stays 0x0001 throughout, IR loaded, pc=0x0040 (not 0x0002).
- pc_write(0xFFFF) then fetch, valid returned -> imem_addr=0xFFFF, pc wraps to 0x0000.
- fetch_req with imem_valid never asserted -> after TIMEOUT=15 cycles fault=1, opcode=0xF, imem_rd=0; further fetch_req ignored until rst_f.
- stat_en with cc=0b0101 during WAIT -> stat=0x5 next edge, fetch unaffected; rst_f asserted mid-WAIT then late imem_valid -> IR=0, pc=0, ir_valid=0.
